// File: rtl/ctrl_carga_elevador_pkg.sv
// Shared definitions for the elevator load/unload sequencer.
// Holds the state encoding, the default sizing and the floor width.
package ctrl_carga_elevador_pkg;
    localparam int LARG_ANDAR        = 2;
    localparam int NUM_ANDARES       = 4;
    localparam int CAPACIDADE_PADRAO = 8;
    localparam int T_PORTA_PADRAO    = 6;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        DESCARGA = 3'd1,
        CARGA    = 3'd2,
        ESCRITA  = 3'd3,
        FECHA    = 3'd4
    } estado_t;
endpackage

// File: rtl/ctrl_carga_elevador_contador.sv
// Per-destination object counters for the elevator cargo.
// Derives occupancy and the full/empty/has-cargo flags.
module contador_destinos
    import ctrl_carga_elevador_pkg::*;
#(
    parameter int CAPACIDADE = CAPACIDADE_PADRAO
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  inc,
    input  logic [LARG_ANDAR-1:0] inc_idx,
    input  logic                  clr,
    input  logic [LARG_ANDAR-1:0] clr_idx,
    output logic [3:0]            ocupacao,
    output logic [3:0]            tem_carga,
    output logic                  cheio,
    output logic                  vazio
);
    logic [3:0] cnt [NUM_ANDARES];

    // The controller never increments and clears the same floor together.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int unsigned f = 0; f < NUM_ANDARES; f++) begin
                cnt[f] <= '0;
            end
        end else begin
            for (int unsigned f = 0; f < NUM_ANDARES; f++) begin
                if (clr && clr_idx == LARG_ANDAR'(f)) begin
                    cnt[f] <= '0;
                end else if (inc && inc_idx == LARG_ANDAR'(f)) begin
                    cnt[f] <= cnt[f] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        ocupacao  = '0;
        tem_carga = '0;
        for (int unsigned f = 0; f < NUM_ANDARES; f++) begin
            ocupacao     = ocupacao + cnt[f];
            tem_carga[f] = (cnt[f] != '0);
        end
    end

    assign cheio = (ocupacao == 4'(CAPACIDADE));
    assign vazio = (ocupacao == '0);
endmodule

// File: rtl/ctrl_carga_elevador.sv
// Load/unload sequencer for the elevator content RAM: unload on arrival,
// door-open load window with valid/ack handshake, then release the car.
module ctrl_carga_elevador
    import ctrl_carga_elevador_pkg::*;
#(
    parameter int CAPACIDADE = CAPACIDADE_PADRAO,
    parameter int T_PORTA    = T_PORTA_PADRAO
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       chegou_andar,
    input  logic [1:0] andar_atual,
    input  logic       req_carga,
    input  logic [1:0] req_tipo,
    input  logic [1:0] req_destino,
    output logic       ack_carga,
    output logic       rejeita,
    output logic       weT,
    output logic [1:0] out_tipo,
    output logic [1:0] out_destino,
    output logic       tira_objetos,
    output logic       porta_aberta,
    output logic       pronto,
    output logic [3:0] ocupacao,
    output logic       cheio,
    output logic       vazio,
    output logic [3:0] tem_carga
);
    localparam int LARG_TIMER = $clog2(T_PORTA + 1);

    estado_t               estado;
    logic [1:0]            andar_reg;
    logic [LARG_TIMER-1:0] timer;
    logic                  inc;
    logic                  clr;

    assign inc = (estado == ESCRITA);
    assign clr = (estado == DESCARGA);

    contador_destinos #(.CAPACIDADE(CAPACIDADE)) u_contador (
        .clk       (clk),
        .clear     (clear),
        .inc       (inc),
        .inc_idx   (out_destino),
        .clr       (clr),
        .clr_idx   (andar_reg),
        .ocupacao  (ocupacao),
        .tem_carga (tem_carga),
        .cheio     (cheio),
        .vazio     (vazio)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            estado       <= OCIOSO;
            andar_reg    <= '0;
            timer        <= '0;
            ack_carga    <= 1'b0;
            rejeita      <= 1'b0;
            weT          <= 1'b0;
            tira_objetos <= 1'b0;
            porta_aberta <= 1'b0;
            pronto       <= 1'b0;
            out_tipo     <= '0;
            out_destino  <= '0;
        end else begin
            ack_carga    <= 1'b0;
            rejeita      <= 1'b0;
            weT          <= 1'b0;
            tira_objetos <= 1'b0;
            pronto       <= 1'b0;
            case (estado)
                OCIOSO: begin
                    porta_aberta <= 1'b0;
                    // Unload decision is taken on the arrival edge so the strobe
                    // coincides with the DESCARGA cycle that clears the counter.
                    if (chegou_andar) begin
                        andar_reg    <= andar_atual;
                        tira_objetos <= tem_carga[andar_atual];
                        estado       <= DESCARGA;
                    end
                end
                DESCARGA: begin
                    timer        <= '0;
                    porta_aberta <= 1'b1;
                    estado       <= CARGA;
                end
                CARGA: begin
                    if (req_carga && req_destino == andar_reg) begin
                        rejeita <= 1'b1;
                        timer   <= '0;
                    end else if (req_carga && !cheio) begin
                        ack_carga   <= 1'b1;
                        out_tipo    <= req_tipo;
                        out_destino <= req_destino;
                        estado      <= ESCRITA;
                    end else if (cheio || timer == LARG_TIMER'(T_PORTA - 1)) begin
                        porta_aberta <= 1'b0;
                        pronto       <= 1'b1;
                        estado       <= FECHA;
                    end else begin
                        timer <= timer + LARG_TIMER'(1);
                    end
                end
                ESCRITA: begin
                    weT    <= 1'b1;
                    timer  <= '0;
                    estado <= CARGA;
                end
                FECHA: begin
                    estado <= OCIOSO;
                end
                default: begin
                    porta_aberta <= 1'b0;
                    estado       <= OCIOSO;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ctrl_carga_elevador.sv
// Directed self-checking bench for ctrl_carga_elevador.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ctrl_carga_elevador;
    logic       clk;
    logic       clear;
    logic       chegou_andar;
    logic [1:0] andar_atual;
    logic       req_carga;
    logic [1:0] req_tipo;
    logic [1:0] req_destino;
    logic       ack_carga;
    logic       rejeita;
    logic       weT;
    logic [1:0] out_tipo;
    logic [1:0] out_destino;
    logic       tira_objetos;
    logic       porta_aberta;
    logic       pronto;
    logic [3:0] ocupacao;
    logic       cheio;
    logic       vazio;
    logic [3:0] tem_carga;

    int unsigned n_testes = 0;
    int unsigned n_falhas = 0;

    ctrl_carga_elevador #(.CAPACIDADE(8), .T_PORTA(6)) dut (
        .clk          (clk),
        .clear        (clear),
        .chegou_andar (chegou_andar),
        .andar_atual  (andar_atual),
        .req_carga    (req_carga),
        .req_tipo     (req_tipo),
        .req_destino  (req_destino),
        .ack_carga    (ack_carga),
        .rejeita      (rejeita),
        .weT          (weT),
        .out_tipo     (out_tipo),
        .out_destino  (out_destino),
        .tira_objetos (tira_objetos),
        .porta_aberta (porta_aberta),
        .pronto       (pronto),
        .ocupacao     (ocupacao),
        .cheio        (cheio),
        .vazio        (vazio),
        .tem_carga    (tem_carga)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic verifica(input string tag, input logic [31:0] obtido,
                            input logic [31:0] esperado);
        n_testes++;
        if (obtido !== esperado) begin
            n_falhas++;
            $display("FAIL %s: obtido=%0h esperado=%0h", tag, obtido, esperado);
        end
    endtask

    // Called on a falling edge; returns on the falling edge of the DESCARGA cycle.
    task automatic chega(input logic [1:0] andar);
        chegou_andar = 1'b1;
        andar_atual  = andar;
        @(negedge clk);
        chegou_andar = 1'b0;
    endtask

    task automatic carrega(input logic [1:0] tipo, input logic [1:0] destino,
                           input string tag);
        logic achou;
        achou       = 1'b0;
        req_carga   = 1'b1;
        req_tipo    = tipo;
        req_destino = destino;
        for (int unsigned n = 0; n < 20 && !achou; n++) begin
            @(negedge clk);
            if (ack_carga) achou = 1'b1;
        end
        verifica({tag, "_ack"}, achou, 1);
        verifica({tag, "_ack_destino"}, out_destino, destino);
        req_carga = 1'b0;
        @(negedge clk);
        verifica({tag, "_weT"}, weT, 1);
        verifica({tag, "_tipo"}, out_tipo, tipo);
        verifica({tag, "_destino"}, out_destino, destino);
    endtask

    // Waits for pronto, counting cycles, open-door cycles and writes seen.
    task automatic espera_pronto(input string tag, output int unsigned ciclos,
                                 output int unsigned abertos,
                                 output int unsigned escritas);
        logic achou;
        achou    = 1'b0;
        ciclos   = 0;
        abertos  = 0;
        escritas = 0;
        for (int unsigned n = 0; n < 40 && !achou; n++) begin
            @(negedge clk);
            ciclos++;
            if (porta_aberta) abertos++;
            if (weT) escritas++;
            if (pronto) achou = 1'b1;
        end
        verifica({tag, "_pronto"}, achou, 1);
        @(negedge clk);
        verifica({tag, "_pronto_1ciclo"}, pronto, 0);
    endtask

    initial begin
        int unsigned ciclos, abertos, escritas;
        logic achou;

        clear        = 1'b1;
        chegou_andar = 1'b0;
        andar_atual  = '0;
        req_carga    = 1'b0;
        req_tipo     = '0;
        req_destino  = '0;
        repeat (2) @(negedge clk);

        verifica("rst_ocupacao", ocupacao, 0);
        verifica("rst_vazio", vazio, 1);
        verifica("rst_cheio", cheio, 0);
        verifica("rst_tem_carga", tem_carga, 4'b0000);
        verifica("rst_strobes", {ack_carga, rejeita, weT, tira_objetos, pronto}, 5'b0);
        verifica("rst_porta", porta_aberta, 0);
        verifica("rst_out", {out_tipo, out_destino}, 4'b0);
        clear = 1'b0;
        @(negedge clk);

        // Empty car at floor 0: no unload, door open for T_PORTA cycles.
        chega(2'd0);
        verifica("vazio_tira", tira_objetos, 0);
        espera_pronto("vazio", ciclos, abertos, escritas);
        verifica("vazio_ciclos", ciclos, 7);
        verifica("vazio_porta_ciclos", abertos, 6);
        verifica("vazio_porta_fechada", porta_aberta, 0);

        // Three loads at floor 0.
        chega(2'd0);
        verifica("carga_tira", tira_objetos, 0);
        carrega(2'd1, 2'd1, "carga0");
        carrega(2'd2, 2'd2, "carga1");
        carrega(2'd3, 2'd2, "carga2");
        verifica("carga_ocupacao", ocupacao, 3);
        verifica("carga_tem_carga", tem_carga, 4'b0110);
        verifica("carga_vazio", vazio, 0);
        espera_pronto("carga", ciclos, abertos, escritas);

        // Unload at floor 2.
        chega(2'd2);
        verifica("desc_tira", tira_objetos, 1);
        @(negedge clk);
        verifica("desc_tira_1ciclo", tira_objetos, 0);
        verifica("desc_ocupacao", ocupacao, 1);
        verifica("desc_tem_carga", tem_carga, 4'b0010);
        espera_pronto("desc", ciclos, abertos, escritas);

        // Fill to capacity from floor 3.
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        verifica("cheio_pre_ocupacao", ocupacao, 0);
        chega(2'd3);
        verifica("cheio_tira", tira_objetos, 0);
        for (int i = 0; i < 8; i++) begin
            carrega(2'(i % 4), 2'(i % 3), "cheio_carga");
        end
        verifica("cheio_ocupacao", ocupacao, 8);
        verifica("cheio_flag", cheio, 1);
        verifica("cheio_tem_carga", tem_carga, 4'b0111);
        req_carga   = 1'b1;
        req_tipo    = 2'd1;
        req_destino = 2'd0;
        @(negedge clk);
        verifica("cheio_sem_ack", ack_carga, 0);
        verifica("cheio_pronto", pronto, 1);
        verifica("cheio_porta", porta_aberta, 0);
        @(negedge clk);
        verifica("cheio_sem_ack2", ack_carga, 0);
        verifica("cheio_ocioso_porta", porta_aberta, 0);
        verifica("cheio_ocupacao_final", ocupacao, 8);
        req_carga = 1'b0;

        // Reject at floor 0 restarts the door timer.
        chega(2'd0);
        verifica("rej_tira", tira_objetos, 1);
        req_carga   = 1'b1;
        req_tipo    = 2'd2;
        req_destino = 2'd0;
        achou       = 1'b0;
        for (int unsigned n = 0; n < 20 && !achou; n++) begin
            @(negedge clk);
            if (rejeita || ack_carga) achou = 1'b1;
        end
        verifica("rej_rejeita", rejeita, 1);
        verifica("rej_sem_ack", ack_carga, 0);
        req_carga = 1'b0;
        espera_pronto("rej", ciclos, abertos, escritas);
        verifica("rej_timer_ciclos", ciclos, 6);
        verifica("rej_sem_weT", escritas, 0);
        verifica("rej_ocupacao", ocupacao, 5);

        // Clear while in ESCRITA suppresses the write.
        chega(2'd1);
        verifica("clr_tira", tira_objetos, 1);
        req_carga   = 1'b1;
        req_tipo    = 2'd3;
        req_destino = 2'd3;
        achou       = 1'b0;
        for (int unsigned n = 0; n < 20 && !achou; n++) begin
            @(negedge clk);
            if (ack_carga) achou = 1'b1;
        end
        verifica("clr_ack", achou, 1);
        clear     = 1'b1;
        req_carga = 1'b0;
        @(negedge clk);
        verifica("clr_sem_weT", weT, 0);
        verifica("clr_ocupacao", ocupacao, 0);
        verifica("clr_vazio", vazio, 1);
        verifica("clr_tem_carga", tem_carga, 4'b0000);
        verifica("clr_porta", porta_aberta, 0);
        clear = 1'b0;
        @(negedge clk);
        verifica("clr_ocioso_porta", porta_aberta, 0);
        verifica("clr_ocioso_weT", weT, 0);
        chega(2'd2);
        verifica("clr_chega_tira", tira_objetos, 0);
        @(negedge clk);
        verifica("clr_chega_porta", porta_aberta, 1);

        $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: obtido=timeout esperado=finish");
        $fatal(1);
    end
endmodule

// File: doc/ctrl_carga_elevador.md
Name: ctrl_carga_elevador

Overview:
Load/unload sequencer for the elevator content RAM (ram_conteudo_elevador). On each floor arrival it issues one unload pulse, then opens the door and accepts floor load requests one at a time through a valid/ack handshake. Each accepted object is written into the RAM. It keeps per-destination object counters so the movement controller knows occupancy and which floors still hold cargo. It sits between the floor request logic, the movement FSM and the RAM.

Parameters:
CAPACIDADE, 8, max objects in elevator (RAM depth)
T_PORTA, 6, consecutive idle cycles in CARGA before the door closes

Ports:
clk  in  1  system clock, rising edge
clear  in  1  synchronous active-high reset
chegou_andar  in  1  pulse: elevator stopped at andar_atual
andar_atual  in  2  current floor
req_carga  in  1  load request valid (held until ack/rejeita)
req_tipo  in  2  object type of request
req_destino  in  2  destination floor of request
ack_carga  out  1  1-cycle pulse: request accepted
rejeita  out  1  1-cycle pulse: request dropped (destino == current floor)
weT  out  1  RAM write strobe
out_tipo  out  2  type to RAM (in_tipo_objeto)
out_destino  out  2  destination to RAM (in_destino_objeto)
tira_objetos  out  1  RAM unload strobe
porta_aberta  out  1  door open
pronto  out  1  1-cycle pulse: floor service done, may depart
ocupacao  out  4  objects on board, 0..CAPACIDADE
cheio  out  1  ocupacao == CAPACIDADE
vazio  out  1  ocupacao == 0
tem_carga  out  4  bit f = 1 iff cnt[f] != 0 (combinational from counters)

Behaviour:
- Reset (clear=1 at edge): state OCIOSO; all cnt[0..3]=0; all strobes, porta_aberta and pronto = 0; out_tipo/out_destino = 0; timer = 0.
- All outputs except tem_carga/cheio/vazio/ocupacao are registered. Strobes last exactly one cycle.
- OCIOSO: chegou_andar=1 -> latch andar_reg<=andar_atual -> DESCARGA. chegou_andar is ignored in every other state.
- DESCARGA (1 cycle): tira_objetos=1 only if cnt[andar_reg]!=0. cnt[andar_reg]<=0. Timer<=0. -> CARGA.
  - Latency: tira_objetos is high in the cycle following the chegou_andar edge.
- CARGA: porta_aberta=1.
  - req_carga && req_destino==andar_reg -> rejeita pulse; stay in CARGA; timer<=0.
  - else req_carga && !cheio -> ack_carga pulse; latch out_tipo/out_destino; -> ESCRITA.
  - cheio -> FECHA immediately; a pending req_carga is not acked.
  - else timer++; when timer==T_PORTA-1 -> FECHA.
- ESCRITA (1 cycle): weT=1 with latched out_tipo/out_destino. cnt[out_destino]++. Timer<=0. porta_aberta stays 1. -> CARGA.
  - Maximum accept rate: one object per 2 cycles.
- FECHA (1 cycle): porta_aberta=0, pronto=1. -> OCIOSO.
- Counters and width:
  - cnt are 4-bit.
  - ocupacao = sum of cnt, 4-bit, never exceeds CAPACIDADE; increments are blocked by the cheio check.
  - Increment and clear never target the same counter in one cycle: the destination is never andar_reg.
- clear has priority over every transition. Asserting it mid-ESCRITA suppresses weT that cycle. The RAM is cleared by the same clear net; this block does not drive the RAM clear.
- Unused states decode to OCIOSO.

Decomposition:
- Shared include/package: state encodings (OCIOSO, DESCARGA, CARGA, ESCRITA, FECHA), CAPACIDADE, T_PORTA default, floor width 2.
- Sub-module contador_destinos: 4x4-bit counter bank with inc/idx and clr/idx ports; produces ocupacao, tem_carga, cheio, vazio.
- FSM, timer and handshake stay in ctrl_carga_elevador.

Test Plan:
- Reset: clear high 2 cycles -> ocupacao=0, vazio=1, tem_carga=0000, all strobes 0, porta_aberta=0.
- Arrival at floor 0, empty elevator: tira_objetos stays 0; porta_aberta high for T_PORTA=6 cycles; then pronto pulses once and the FSM returns to OCIOSO.
- Load at floor 0: three requests (tipo 1,2,3 / destino 1,2,2), each held until ack. Expect 3 ack_carga pulses, each followed next cycle by weT with matching data; then ocupacao=3, tem_carga=0110.
- Unload at floor 2 (continuing from the previous scenario): chegou_andar with andar_atual=2 -> tira_objetos pulses the next cycle; ocupacao=1, tem_carga=0010.
- Full: 8 accepted loads, then a 9th request -> no ack_carga; cheio=1; FECHA entered and pronto pulses; req_carga still high after pronto.
- Reject and reset: request with destino==current floor -> rejeita pulse, no weT, timer restarts. Then clear asserted during ESCRITA -> no weT, all counters 0, state OCIOSO.
